// File: rtl/addsubw_pipe_pkg.sv
// Shared op codes and per-transaction flag bundle for the add/sub pipeline.
package addsubw_pipe_pkg;

  localparam logic [2:0] ADD   = 3'b000;
  localparam logic [2:0] SUB   = 3'b001;
  localparam logic [2:0] ADDC  = 3'b010;
  localparam logic [2:0] SUBB  = 3'b011;
  localparam logic [2:0] ADDUS = 3'b100;
  localparam logic [2:0] SUBUS = 3'b101;
  localparam logic [2:0] ADDSS = 3'b110;
  localparam logic [2:0] SUBSS = 3'b111;

  typedef struct packed {
    logic en;
    logic cout;
    logic ovf;
  } meta_t;

  // Every odd op code is a subtraction.
  function automatic logic op_is_sub(input logic [2:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/addsubw_pipe_if.sv
// Operand/result bus with valid-ready handshakes; master drives operands, slave returns results.
interface addsubw_pipe_if #(parameter int width = 16);

  logic [width-1:0] i0;
  logic [width-1:0] i1;
  logic [2:0]       op;
  logic             cin;
  logic             pred;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] o0;
  logic             o0_enable;
  logic             cout;
  logic             ovf;
  logic             ovf_sticky;
  logic             clr_sticky;

  modport master (
    output i0, i1, op, cin, pred, in_valid, out_ready, clr_sticky,
    input  in_ready, out_valid, o0, o0_enable, cout, ovf, ovf_sticky
  );

  modport slave (
    input  i0, i1, op, cin, pred, in_valid, out_ready, clr_sticky,
    output in_ready, out_valid, o0, o0_enable, cout, ovf, ovf_sticky
  );

endinterface

// File: rtl/addsub_core.sv
// Combinational add/sub with carry/borrow, wrap or saturate; 0 cycles latency, no backpressure.
module addsub_core
  import addsubw_pipe_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0] i_a,
  input  logic [width-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_cin,
  output logic [width-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic             w_sub;
  logic             w_ci;
  logic             w_sov;
  logic [width-1:0] w_b;
  logic [width:0]   w_full;

  always_comb begin
    w_sub = op_is_sub(i_op);
    w_b   = w_sub ? ~i_b : i_b;
    case (i_op)
      ADDC:    w_ci = i_cin;
      SUBB:    w_ci = !i_cin;
      default: w_ci = w_sub;
    endcase
    w_full = {1'b0, i_a} + {1'b0, w_b} + {{width{1'b0}}, w_ci};
    // Subtraction reports borrow, hence the inversion of the raw carry.
    o_cout = w_full[width] ^ w_sub;
    w_sov  = (i_a[width-1] == w_b[width-1]) && (w_full[width-1] != i_a[width-1]);
    o_sum  = w_full[width-1:0];
    o_ovf  = 1'b0;
    case (i_op)
      ADDC, SUBB: o_ovf = o_cout;
      ADDUS: begin
        o_ovf = o_cout;
        if (o_cout) o_sum = '1;
      end
      SUBUS: begin
        o_ovf = o_cout;
        if (o_cout) o_sum = '0;
      end
      ADDSS, SUBSS: begin
        o_ovf = w_sov;
        if (w_sov) o_sum = i_a[width-1] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
      end
      default: o_ovf = 1'b0;
    endcase
  end

endmodule

// File: rtl/addsubw_pipe.sv
// Pipelined add/sub with sticky overflow; latency = stages cycles.
// Backpressure: out_ready=0 stalls the chain, bubbles collapse, in_ready drops only when full.
module addsubw_pipe
  import addsubw_pipe_pkg::*;
#(
  parameter int width  = 16,
  parameter int stages = 2
) (
  input logic           clk,
  input logic           reset_n,
  addsubw_pipe_if.slave bus
);

  logic [width-1:0]  w_sum;
  logic              w_cout;
  logic              w_ovf;
  meta_t             w_meta;
  logic [stages-1:0] w_take;
  logic              w_all_full;
  logic              w_rdy;
  logic              w_acc;
  logic              w_dlv;

  logic [stages-1:0] r_vld;
  logic [width-1:0]  r_dat  [stages];
  meta_t             r_meta [stages];
  logic              r_run;
  logic              r_sticky;

  addsub_core #(.width(width)) u_core (
    .i_a    (bus.i0),
    .i_b    (bus.i1),
    .i_op   (bus.op),
    .i_cin  (bus.cin),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_ovf)
  );

  // A stage may load when out_ready drains the chain or some stage at/after it is empty.
  always_comb begin
    w_all_full = 1'b1;
    w_take     = '0;
    for (int i = stages - 1; i >= 0; i--) begin
      w_all_full = w_all_full & r_vld[i];
      w_take[i]  = bus.out_ready | !w_all_full;
    end
  end

  assign w_rdy  = r_run & w_take[0];
  assign w_acc  = bus.in_valid & w_rdy;
  assign w_dlv  = r_vld[stages-1] & bus.out_ready;
  assign w_meta = '{en: bus.pred, cout: bus.pred & w_cout, ovf: bus.pred & w_ovf};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld    <= '0;
      r_run    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_take[0]) r_vld[0] <= w_acc;
      for (int i = 1; i < stages; i++) begin
        if (w_take[i]) r_vld[i] <= r_vld[i-1];
      end
      if (w_dlv && r_meta[stages-1].ovf) r_sticky <= 1'b1;
      else if (bus.clr_sticky)           r_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_take[0] && w_acc) begin
      r_dat[0]  <= bus.pred ? w_sum : '0;
      r_meta[0] <= w_meta;
    end
    for (int i = 1; i < stages; i++) begin
      if (w_take[i] && r_vld[i-1]) begin
        r_dat[i]  <= r_dat[i-1];
        r_meta[i] <= r_meta[i-1];
      end
    end
  end

  // Result lines are qualified by the last valid bit, so reset zeroes them without resetting data.
  assign bus.in_ready   = w_rdy;
  assign bus.out_valid  = r_vld[stages-1];
  assign bus.o0         = r_vld[stages-1] ? r_dat[stages-1] : '0;
  assign bus.o0_enable  = r_vld[stages-1] & r_meta[stages-1].en;
  assign bus.cout       = r_vld[stages-1] & r_meta[stages-1].cout;
  assign bus.ovf        = r_vld[stages-1] & r_meta[stages-1].ovf;
  assign bus.ovf_sticky = r_sticky;

endmodule

// File: tb/tb_addsubw_pipe.sv
// Bench for addsubw_pipe (width=8, stages=2): arithmetic model plus directed vectors.
module tb_addsubw_pipe;
  import addsubw_pipe_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  typedef struct packed {
    logic [7:0] o0;
    logic       cout;
    logic       ovf;
    logic       en;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  addsubw_pipe_if #(.width(W)) bus ();
  addsubw_pipe #(.width(W), .stages(S)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int   checks = 0;
  int   failures = 0;
  int   delivered = 0;
  exp_t q[$];
  exp_t f;
  logic m_sticky = 1'b0;
  logic m_set;
  logic prev_stall = 1'b0;
  logic [10:0] p_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci, input logic p);
    int ua, ub, sa, sb, c, r;
    exp_t e;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); c = ci;
    e = '0;
    r = 0;
    case (op)
      3'd0: begin r = ua + ub; e.cout = (r > 255); end
      3'd1: begin r = ua - ub; e.cout = (r < 0); end
      3'd2: begin r = ua + ub + c; e.cout = (r > 255); e.ovf = e.cout; end
      3'd3: begin r = ua - ub - c; e.cout = (r < 0); e.ovf = e.cout; end
      3'd4: begin r = ua + ub; e.cout = (r > 255); e.ovf = e.cout; if (e.ovf) r = 255; end
      3'd5: begin r = ua - ub; e.cout = (r < 0); e.ovf = e.cout; if (e.ovf) r = 0; end
      3'd6: begin
        e.cout = ((ua + ub) > 255);
        r = sa + sb;
        e.ovf = (r > 127) || (r < -128);
      end
      default: begin
        e.cout = (ua < ub);
        r = sa - sb;
        e.ovf = (r > 127) || (r < -128);
      end
    endcase
    if (r > 127 && op[1] && op[2]) r = 127;
    if (r < -128 && op[1] && op[2]) r = -128;
    e.o0 = r[7:0];
    e.en = 1'b1;
    if (!p) e = '0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_sticky = 1'b0;
      prev_stall = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_sticky", bus.ovf_sticky, 0);
      chk("rst_outputs", {bus.o0, bus.o0_enable, bus.cout, bus.ovf}, 0);
    end else begin
      chk("sticky", bus.ovf_sticky, m_sticky);
      if (prev_stall) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", {bus.o0, bus.cout, bus.ovf, bus.o0_enable}, p_out);
      end
      m_set = 1'b0;
      if (bus.out_valid) begin
        chk("out_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          f = q[0];
          chk("o0", bus.o0, f.o0);
          chk("cout", bus.cout, f.cout);
          chk("ovf", bus.ovf, f.ovf);
          chk("o0_enable", bus.o0_enable, f.en);
          if (bus.out_ready) begin
            m_set = f.ovf;
            void'(q.pop_front());
            delivered++;
          end
        end
      end
      m_sticky = m_set ? 1'b1 : (bus.clr_sticky ? 1'b0 : m_sticky);
      prev_stall = bus.out_valid & !bus.out_ready;
      p_out = {bus.o0, bus.cout, bus.ovf, bus.o0_enable};
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.op, bus.i0, bus.i1, bus.cin, bus.pred));
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic p);
    logic done;
    done = 1'b0;
    bus.op = op; bus.i0 = a; bus.i1 = b; bus.cin = ci; bus.pred = p; bus.in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic wait_out();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL out_timeout actual=no_valid required=valid");
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h7F, 8'h80};
  int lat;
  int d0;

  initial begin
    bus.i0 = '0; bus.i1 = '0; bus.op = '0; bus.cin = 0; bus.pred = 0;
    bus.in_valid = 0; bus.out_ready = 1; bus.clr_sticky = 0;

    chk("model_add", model(ADD, 8'hF0, 8'h20, 0, 1), {8'h10, 1'b1, 1'b0, 1'b1});
    chk("model_subus", model(SUBUS, 8'h05, 8'h09, 0, 1), {8'h00, 1'b1, 1'b1, 1'b1});
    chk("model_addss", model(ADDSS, 8'h70, 8'h20, 0, 1), {8'h7F, 1'b0, 1'b1, 1'b1});
    chk("model_subss", model(SUBSS, 8'h80, 8'h01, 0, 1), {8'h80, 1'b0, 1'b1, 1'b1});
    chk("model_subb", model(SUBB, 8'h10, 8'h10, 1, 1), {8'hFF, 1'b1, 1'b1, 1'b1});
    chk("model_addc", model(ADDC, 8'hFF, 8'h00, 1, 1), {8'h00, 1'b1, 1'b1, 1'b1});

    cyc(3);
    reset_n = 1'b1;
    @(negedge clk);
    chk("in_ready_before_edge", bus.in_ready, 0);
    cyc(1);
    chk("in_ready_after_edge", bus.in_ready, 1);

    send(ADD, 8'hF0, 8'h20, 0, 1);
    lat = 1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      cyc(1);
      lat++;
    end
    chk("latency", lat, S);
    chk("add_o0", bus.o0, 8'h10);
    chk("add_flags", {bus.cout, bus.ovf, bus.o0_enable}, 3'b101);
    cyc(1);

    send(SUBUS, 8'h05, 8'h09, 0, 1);
    wait_out();
    chk("subus_o0", bus.o0, 8'h00);
    chk("subus_ovf", bus.ovf, 1);
    cyc(1);
    chk("subus_sticky_set", bus.ovf_sticky, 1);
    bus.clr_sticky = 1'b1;
    cyc(1);
    bus.clr_sticky = 1'b0;
    chk("sticky_cleared", bus.ovf_sticky, 0);

    send(ADDSS, 8'h70, 8'h20, 0, 1);
    send(SUBSS, 8'h80, 8'h01, 0, 1);
    wait_out();
    chk("addss_o0", bus.o0, 8'h7F);
    chk("addss_ovf", bus.ovf, 1);
    cyc(1);
    wait_out();
    chk("subss_o0", bus.o0, 8'h80);
    chk("subss_ovf", bus.ovf, 1);
    cyc(1);

    send(ADD, 8'h01, 8'h01, 0, 0);
    wait_out();
    chk("pred0_o0", bus.o0, 8'h00);
    chk("pred0_en", bus.o0_enable, 0);
    cyc(1);
    chk("pred0_sticky_kept", bus.ovf_sticky, 1);
    bus.clr_sticky = 1'b1;
    cyc(1);
    bus.clr_sticky = 1'b0;
    send(ADDUS, 8'hFF, 8'hFF, 0, 0);
    wait_out();
    chk("pred0_ovf_masked", bus.ovf, 0);
    cyc(1);
    chk("pred0_no_sticky", bus.ovf_sticky, 0);

    fork
      begin
        for (int o = 0; o < 8; o++)
          for (int i = 0; i < 4; i++)
            send(3'(o), va[i], va[(i + 1) % 4], i[0], 1'b1);
      end
      begin
        for (int k = 0; k < 60; k++) begin
          bus.out_ready = (k % 3 != 1);
          cyc(1);
        end
        bus.out_ready = 1'b1;
      end
    join
    cyc(6);
    chk("sweep_drained", q.size(), 0);

    d0 = delivered;
    fork
      begin
        for (int k = 0; k < 10; k++)
          send(3'(k % 8), 8'(k * 37), 8'(8'h30 + k), k[0], 1'b1);
      end
      begin
        cyc(3);
        bus.out_ready = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        cyc(2);
        bus.out_ready = 1'b1;
      end
    join
    cyc(6);
    chk("burst_delivered", delivered - d0, 10);
    chk("burst_drained", q.size(), 0);

    bus.out_ready = 1'b0;
    send(ADD, 8'h01, 8'h02, 0, 1);
    send(SUB, 8'h05, 8'h03, 0, 1);
    d0 = delivered;
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    chk("midrst_in_ready_after", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    cyc(8);
    chk("midrst_nothing_delivered", delivered - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/addsubw_pipe.md
ADDSUBW_PIPE -- requirements
Module: addsubw_pipe

Interface
REQ-001 SHALL have parameter width, default 16, meaning the operand and result width (legal values 2..64).
REQ-002 SHALL have parameter stages, default 2, meaning the pipeline depth in register stages (legal values 1..4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports i0 and i1, input, width bits each: the operands.
REQ-006 SHALL have port op, input, 3 bits: the operation code (REQ-014).
REQ-007 SHALL have port cin, input, 1 bit: carry-in for op 010, borrow-in for op 011.
REQ-008 SHALL have port pred, input, 1 bit: the predicate for the transaction.
REQ-009 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): the input handshake.
REQ-010 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): the output handshake.
REQ-011 SHALL have port o0, output, width bits: the result.
REQ-012 SHALL have ports o0_enable, cout and ovf, output, 1 bit each: the reflected pred, the carry/borrow-out, and the overflow/saturation flag.
REQ-013 SHALL have ports ovf_sticky (output, 1 bit) and clr_sticky (input, 1 bit): the accumulated overflow flag and its synchronous clear.

Function
REQ-014 SHALL decode op as follows:
- 000 add, wrap-around.
- 001 sub, wrap-around.
- 010 add with cin.
- 011 sub with borrow cin.
- 100 unsigned saturating add.
- 101 unsigned saturating sub (floor 0).
- 110 signed saturating add.
- 111 signed saturating sub (clamp to signed max/min).
REQ-015 SHALL compute subtraction as i0 + ~i1 + 1, and sub-with-borrow as i0 + ~i1 + !cin.
REQ-016 SHALL compute the sum at width+1 bits; cout is bit width, and for subtraction it is inverted so that 1 means borrow.
REQ-017 SHALL define ovf for each op:
- 000, 001: always 0.
- 010, 011: cout.
- 100, 101: unsigned over/underflow.
- 110, 111: signed overflow (operand sign mismatch rule).
REQ-018 SHALL accept a transaction on any clock edge where in_valid and in_ready are both 1.
REQ-019 SHALL deliver a transaction on any clock edge where out_valid and out_ready are both 1.
REQ-020 SHALL present an accepted transaction on the outputs exactly stages cycles after acceptance when out_ready is held 1; order is preserved and nothing is dropped or duplicated.
REQ-021 SHALL give each stage a valid bit; a stage loads when it is empty or its contents advance on the same edge.
REQ-022 SHALL drive in_ready = !valid[0] or stage 0 advancing, so a full pipeline with out_ready=1 sustains 1 transaction per cycle.
REQ-023 SHALL hold o0, o0_enable, cout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL still carry a pred=0 transaction through the pipeline and handshake, but deliver it with o0=0, cout=0, ovf=0 and o0_enable=0.
REQ-025 SHALL set ovf_sticky on the delivery edge of any transaction with ovf=1 and pred=1; clr_sticky=1 clears it, and a simultaneous set wins over clear.
REQ-026 SHALL treat in_valid as ignored when in_ready=0, and SHALL NOT require out_ready to be held between transactions.
REQ-027 SHALL leave the datapath registers without a reset.

Reset
REQ-028 SHALL, while reset_n=0, force all stage valid bits, out_valid, ovf_sticky, o0, o0_enable, cout and ovf to 0, and in_ready to 0.
REQ-029 SHALL discard any in-flight transactions when reset asserts mid-operation.
REQ-030 SHALL drive in_ready=1 on the first clk edge after reset_n deasserts.

Structure
REQ-031 SHALL place the op codes (ADD, SUB, ADDC, SUBB, ADDUS, SUBUS, ADDSS, SUBSS) as named constants in the shared macrocell package.
REQ-032 SHALL contain one combinational sub-module, addsub_core: operands, op, cin -> sum, cout, ovf, which feeds stage 0.
REQ-033 SHALL implement the remaining stages as a uniform valid/data register chain.

Verification (width=8, stages=2)
REQ-034 SHALL cover: op=000, i0=0xF0, i1=0x20, pred=1, out_ready=1 -> after 2 cycles o0=0x10, cout=1, ovf=0, o0_enable=1.
REQ-035 SHALL cover: op=101, i0=0x05, i1=0x09 -> o0=0x00, ovf=1, ovf_sticky=1 after delivery; then clr_sticky pulse -> ovf_sticky=0.
REQ-036 SHALL cover: op=110, i0=0x70, i1=0x20 -> o0=0x7F, ovf=1; op=111, i0=0x80, i1=0x01 -> o0=0x80, ovf=1.
REQ-037 SHALL cover: 10 back-to-back transactions with out_ready=0 for cycles 3-6 -> in_ready=0 once full, outputs held stable, all 10 delivered in order.
REQ-038 SHALL cover: pred=0, op=000, i0=0x01, i1=0x01 -> delivered with o0=0x00, o0_enable=0, ovf_sticky unchanged.
REQ-039 SHALL cover: reset_n pulsed low with 2 transactions in flight -> out_valid=0 immediately, neither transaction is ever delivered, and in_ready=1 after release.
